// File: rtl/hilo_pkg.sv
// Purpose: shared types and constants for the HI/LO multiply sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hilo_pkg;

  // Sequencer states around the multi-cycle multiplier.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  // ReadSel encodings.
  localparam logic SEL_LO = 1'b0;
  localparam logic SEL_HI = 1'b1;

  // Default give-up point for a multiply that never reports done.
  localparam int TIMEOUT_CYCLES_DEF = 40;
  localparam int CNT_W_DEF          = 6;

endpackage

// File: rtl/hilo_regs.sv
// Purpose: architectural HI/LO storage with MT write port, capture port and read mux.
// Latency: writes land on the next clk edge; read mux is combinational.
// Backpressure: none; capture and MT writes are always accepted, capture wins a collision.
//
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_mt_hi, i_mt_lo        MTHI/MTLO write strobes, data on i_wr_dat
//   i_cap_vld               multiply result capture, data on i_cap_hi/i_cap_lo
//   i_rd_sel                0 = LO, 1 = HI
//   o_rd_dat                selected register value
module hilo_regs
  import hilo_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mt_hi,
  input  logic        i_mt_lo,
  input  logic [31:0] i_wr_dat,
  input  logic        i_cap_vld,
  input  logic [31:0] i_cap_hi,
  input  logic [31:0] i_cap_lo,
  input  logic        i_rd_sel,
  output logic [31:0] o_rd_dat
);

  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // A capture replaces both halves, so it overrides any MT write on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (i_cap_vld) begin
      r_hi <= i_cap_hi;
      r_lo <= i_cap_lo;
    end else begin
      if (i_mt_hi) r_hi <= i_wr_dat;
      if (i_mt_lo) r_lo <= i_wr_dat;
    end
  end

  assign o_rd_dat = (i_rd_sel == SEL_HI) ? r_hi : r_lo;

endmodule

// File: rtl/hilo_ctrl.sv
// Purpose: MULT sequencer around the Booth multiplier and owner of HI/LO.
// Latency: accept at edge 0, MultIn during cycle 1, capture on first WAIT edge seeing MultOut.
// Backpressure: Stall holds the pipeline for MultStart or HI/LO reads while a multiply is in flight.
//
// Ports:
//   clk, Reset                    clock, async active-low reset
//   MultStart, OpA, OpB           MULT request from control (held until accepted)
//   MultIn, MultA, MultB          start pulse and latched operands to the multiplier
//   MultHigh, MultLow, MultOut    multiplier result and level done flag
//   ReadReq, ReadSel, ReadData    MFHI/MFLO port (ReadSel 0 = LO, 1 = HI)
//   MtHi, MtLo, WriteData         MTHI/MTLO port
//   Busy, Stall, MultErr          status: in flight, pipeline hold, sticky timeout
//
// Build option: define HILO_FORWARD_EN to serve a read on the capture cycle
// straight from MultHigh/MultLow instead of stalling one extra cycle.
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        MultStart,
  input  logic [31:0] OpA,
  input  logic [31:0] OpB,
  output logic        MultIn,
  output logic [31:0] MultA,
  output logic [31:0] MultB,
  input  logic [31:0] MultHigh,
  input  logic [31:0] MultLow,
  input  logic        MultOut,
  input  logic        ReadReq,
  input  logic        ReadSel,
  output logic [31:0] ReadData,
  input  logic        MtHi,
  input  logic        MtLo,
  input  logic [31:0] WriteData,
  output logic        Busy,
  output logic        Stall,
  output logic        MultErr
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mult_in;
  logic [31:0]        r_mult_a;
  logic [31:0]        r_mult_b;
  logic               r_err;

  logic               w_cap;
  logic [31:0]        w_reg_dat;

  // MultOut is only trusted in WAIT: the multiplier drops any stale done flag
  // on the LAUNCH edge, so WAIT never sees the previous result's flag.
  assign w_cap = (r_state == WAIT) && MultOut;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_mult_in <= 1'b0;
      r_mult_a  <= '0;
      r_mult_b  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_mult_in <= 1'b0;
      case (r_state)
        IDLE: begin
          if (MultStart) begin
            r_mult_a  <= OpA;
            r_mult_b  <= OpB;
            r_err     <= 1'b0;
            r_mult_in <= 1'b1;
            r_state   <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (MultOut) begin
            r_state <= IDLE;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Abandon the multiply; HI/LO keep their previous contents.
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  hilo_regs u_regs (
    .i_clk     (clk),
    .i_rst_n   (Reset),
    .i_mt_hi   (MtHi),
    .i_mt_lo   (MtLo),
    .i_wr_dat  (WriteData),
    .i_cap_vld (w_cap),
    .i_cap_hi  (MultHigh),
    .i_cap_lo  (MultLow),
    .i_rd_sel  (ReadSel),
    .o_rd_dat  (w_reg_dat)
  );

  assign MultIn  = r_mult_in;
  assign MultA   = r_mult_a;
  assign MultB   = r_mult_b;
  assign MultErr = r_err;
  assign Busy    = (r_state != IDLE);

`ifdef HILO_FORWARD_EN
  // On the capture cycle the result is already on MultHigh/MultLow, so a
  // read can bypass the registers instead of waiting for them to update.
  assign ReadData = w_cap ? ((ReadSel == SEL_LO) ? MultLow : MultHigh) : w_reg_dat;
  assign Stall    = (ReadReq & Busy & ~w_cap) | (MultStart & Busy);
`else
  assign ReadData = w_reg_dat;
  assign Stall    = (ReadReq & Busy) | (MultStart & Busy);
`endif

endmodule

// File: doc/hilo_ctrl.md
Name: hilo_ctrl

Overview:
- Sequencer and HI/LO register owner that sits directly around the multi-cycle Booth multiplier in the MIPS datapath.
- Upstream role: accepts MULT requests from the control unit, latches the operands and issues the single-cycle MultIn start pulse.
- Downstream role: captures resultHigh/resultLow when MultOut is seen, and holds them in architectural HI/LO.
- Serves MFHI/MFLO/MTHI/MTLO, and stalls the pipeline when HI/LO is read while a multiply is in flight.

Parameters:
- TIMEOUT_CYCLES, 40, maximum cycles spent in WAIT before the multiply is abandoned (must be greater than 34).
- CNT_W, 6, width of the WAIT-cycle counter (2^CNT_W must be greater than TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- MultStart  in  1  control unit requests MULT (signed); held by control until accepted.
- OpA  in  32  rs operand.
- OpB  in  32  rt operand.
- MultIn  out  1  start pulse to the multiplier.
- MultA  out  32  latched multiplicand to the multiplier.
- MultB  out  32  latched multiplier operand to the multiplier.
- MultHigh  in  32  multiplier resultHigh.
- MultLow  in  32  multiplier resultLow.
- MultOut  in  1  multiplier done flag (level; stays high until the next MultIn).
- ReadReq  in  1  MFHI/MFLO request.
- ReadSel  in  1  0 = LO, 1 = HI.
- ReadData  out  32  selected HI/LO value (combinational).
- MtHi  in  1  MTHI write strobe.
- MtLo  in  1  MTLO write strobe.
- WriteData  in  32  MTHI/MTLO data.
- Busy  out  1  multiply in flight.
- Stall  out  1  pipeline hold request.
- MultErr  out  1  sticky timeout flag.

Behaviour:
- Reset (asynchronous, Reset = 0): state IDLE; HI, LO, MultA, MultB cleared to 0; WAIT counter cleared; MultIn = 0, Busy = 0, MultErr = 0. Stall = 0, ReadData = 0.
- State machine, three states:
  - IDLE: MultStart = 1 → latch OpA/OpB into MultA/MultB, clear MultErr, go to LAUNCH.
  - LAUNCH: exactly one cycle; MultIn = 1; counter cleared; go to WAIT.
  - WAIT: MultIn = 0; counter increments each cycle.
    - MultOut = 1 on an edge → HI <= MultHigh, LO <= MultLow, go to IDLE.
    - Counter reaches TIMEOUT_CYCLES − 1 without MultOut → MultErr <= 1, HI/LO unchanged, go to IDLE.
- A stale MultOut = 1 is never sampled: it is only examined in WAIT, which begins after the multiplier has cleared it on the LAUNCH edge.
- Busy = (state != IDLE).
- Latency, nominal: MultStart accepted at edge 0, MultIn high during cycle 1. The multiplier raises MultOut after 32 further edges; HI/LO are updated on the first WAIT edge that sees it. Busy is low two cycles after the MultIn pulse ends plus 32.
- MultA/MultB are held constant from acceptance until the next acceptance.
- Stall = (ReadReq & Busy) | (MultStart & Busy). A MultStart while Busy is not accepted; control holds it until IDLE.
- ReadData = ReadSel ? HI : LO, valid whenever Stall = 0.
- MTHI/MTLO:
  - Write on the edge regardless of state.
  - A later WAIT capture overwrites both HI and LO (multiply result wins).
  - Same-edge MtHi and MultOut capture: the capture wins.
- A MultStart accepted in the same cycle as MtHi/MtLo is legal; the write lands first and the capture overwrites it later.
- Reset asserted mid-operation aborts the multiply with no HI/LO update. A multiplier still counting is harmless: its MultOut is ignored outside WAIT.

Optional Feature:
- Macro: HILO_FORWARD_EN.
- Defined: in WAIT with MultOut = 1, a ReadReq gets ReadData from MultHigh/MultLow (per ReadSel) and Stall is not asserted for that request, saving one stall cycle.
- Undefined: a read in that cycle stalls, and is served from HI/LO on the following cycle.

Decomposition:
- Shared package hilo_pkg:
  - state enum {IDLE, LAUNCH, WAIT};
  - ReadSel encodings SEL_LO = 0, SEL_HI = 1;
  - default TIMEOUT_CYCLES constant.
- Sub-module hilo_regs (HI/LO storage, MT write port, capture port with capture priority, read mux) is natural. FSM and counter stay in hilo_ctrl.

Test Plan:
- Reset, then OpA = 7, OpB = −3 (0xFFFFFFFD), MultStart → exactly one MultIn pulse; Busy high ~34 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFEB, MultErr = 0.
- During that multiply, ReadReq = 1, ReadSel = 1 → Stall high until the capture edge; next cycle ReadData = 0xFFFFFFFF.
- Idle, MtHi with WriteData = 0x12345678, then MtLo with WriteData = 0x9ABCDEF0 → reads return the written values with no stall.
- MtLo = 0xAAAA0000 during WAIT of 0x00010000 × 0x00010000 → after capture HI = 0x00000001, LO = 0x00000000.
- Multiplier model never raises MultOut → MultErr = 1 after TIMEOUT_CYCLES in WAIT, Busy = 0, HI/LO unchanged; the next MultStart clears MultErr.
- Reset pulsed low mid-WAIT → all outputs zero immediately; a late MultOut produces no HI/LO write.
- With HILO_FORWARD_EN, MFLO issued on the capture cycle → Stall = 0 and ReadData = MultLow that cycle.
